// File: rtl/credit_source_arbiter.sv
// Round-robin packet arbiter feeding a credit-controlled streaming sink.
// Holds sink credits, spends one per beat and can hand them back on flush.
module credit_source_arbiter #(
    parameter int data_width    = 128,
    parameter int empty_width   = 4,
    parameter int channel_width = 10,
    parameter int credit_width  = 5,
    parameter int num_req       = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [num_req-1:0]               avsi_valid,
    output logic [num_req-1:0]               avsi_ready,
    input  logic [num_req*data_width-1:0]    avsi_data,
    input  logic [num_req*channel_width-1:0] avsi_channel,
    input  logic [num_req-1:0]               avsi_sop,
    input  logic [num_req-1:0]               avsi_eop,
    input  logic [num_req*empty_width-1:0]   avsi_empty,
    output logic                             avso_valid,
    output logic [data_width-1:0]            avso_data,
    output logic [channel_width-1:0]         avso_channel,
    output logic                             avso_sop,
    output logic                             avso_eop,
    output logic [empty_width-1:0]           avso_empty,
    input  logic                             update_credit,
    input  logic [credit_width-1:0]          credit,
    output logic                             return_credit,
    input  logic                             credit_flush,
    output logic [credit_width:0]            credit_cnt,
    output logic                             credit_err
);
    localparam int gw = (num_req > 1) ? $clog2(num_req) : 1;
    localparam int sw = credit_width + 2;
    localparam logic [sw-1:0] cmax = sw'(1 << credit_width);

    typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;

    state_t                   state;
    logic [gw-1:0]            grant;
    logic [gw-1:0]            last_grant;
    logic [gw-1:0]            pick;
    logic                     pick_ok;
    logic                     accept;
    logic                     flush_return;
    logic [sw-1:0]            avail;
    logic [sw-1:0]            debit;
    logic [sw-1:0]            sum;
    logic                     underflow;
    logic                     overflow;
    logic [data_width-1:0]    sel_data;
    logic [channel_width-1:0] sel_channel;
    logic [empty_width-1:0]   sel_empty;
    logic                     sel_sop;
    logic                     sel_eop;

    // Descending scan so the nearest requester after last_grant wins.
    always_comb begin
        int idx;
        idx     = 0;
        pick    = last_grant;
        pick_ok = 1'b0;
        for (int k = num_req; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= num_req) idx = idx - num_req;
            if (avsi_valid[idx]) begin
                pick    = gw'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        avsi_ready = '0;
        if (state == XFER && credit_cnt != '0) avsi_ready[grant] = 1'b1;
    end

    always_comb begin
        sel_data    = avsi_data[int'(grant)*data_width +: data_width];
        sel_channel = avsi_channel[int'(grant)*channel_width +: channel_width];
        sel_empty   = avsi_empty[int'(grant)*empty_width +: empty_width];
        sel_sop     = avsi_sop[grant];
        sel_eop     = avsi_eop[grant];
    end

    assign accept       = |(avsi_valid & avsi_ready);
    assign avail        = {1'b0, credit_cnt} + (update_credit ? sw'(credit) : '0);
    assign flush_return = (state == FLUSH) && credit_flush && (avail != '0);
    assign debit        = sw'(accept) + sw'(flush_return);
    assign underflow    = avail < debit;
    assign sum          = avail - debit;
    assign overflow     = !underflow && (sum > cmax);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= gw'(num_req - 1);
            credit_cnt    <= '0;
            credit_err    <= 1'b0;
            return_credit <= 1'b0;
            avso_valid    <= 1'b0;
            avso_sop      <= 1'b0;
            avso_eop      <= 1'b0;
            avso_data     <= '0;
            avso_channel  <= '0;
            avso_empty    <= '0;
        end else begin
            avso_valid    <= accept;
            return_credit <= flush_return;
            if (underflow) begin
                credit_cnt <= '0;
                credit_err <= 1'b1;
            end else if (overflow) begin
                credit_cnt <= cmax[credit_width:0];
                credit_err <= 1'b1;
            end else begin
                credit_cnt <= sum[credit_width:0];
            end
            if (accept) begin
                avso_data    <= sel_data;
                avso_channel <= sel_channel;
                avso_sop     <= sel_sop;
                avso_eop     <= sel_eop;
                avso_empty   <= sel_eop ? sel_empty : '0;
            end
            unique case (state)
                IDLE: begin
                    if (credit_flush) begin
                        state <= FLUSH;
                    end else if (pick_ok) begin
                        grant <= pick;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (accept && sel_eop) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                FLUSH: begin
                    if (!credit_flush || (credit_cnt == '0 && !update_credit))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
